// File: rtl/aes_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : aes_round_ctrl                                                 |
// | Brief   : AES encrypt round sequencer: ark/round/mix strobes and rcon.   |
// |           Optional stall input when AES_CTRL_STALL_EN is defined.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module aes_round_ctrl #(
  parameter  int NR = 10,
  localparam int RW = $clog2(NR + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ark_init,
  output logic          round_en,
  output logic          mix_en,
  output logic [RW-1:0] round,
  output logic          rcon_step,
  output logic [7:0]    rcon,
  output logic          out_valid,
  input  logic          out_ready
`ifdef AES_CTRL_STALL_EN
  ,
  input  logic          stall
`endif
);

  generate
    if (NR != 10 && NR != 14) begin : g_bad_nr
      $error("aes_round_ctrl: NR must be 10 or 14");
    end
  endgenerate

  localparam logic [1:0]    c_IDLE    = 2'd0;
  localparam logic [1:0]    c_INIT    = 2'd1;
  localparam logic [1:0]    c_ROUND   = 2'd2;
  localparam logic [1:0]    c_DONE    = 2'd3;
  localparam logic [RW-1:0] c_NR_LAST = RW'(NR);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          ark_q, ark_d;
  logic          ren_q, ren_d;
  logic          mix_q, mix_d;
  logic          step_q, step_d;
  logic          ov_q, ov_d;
  logic          w_stall;
  logic          w_adv;
  logic [7:0]    w_xtime;

`ifdef AES_CTRL_STALL_EN
  assign w_stall = stall && ((state_q == c_INIT) || (state_q == c_ROUND));
`else
  assign w_stall = 1'b0;
`endif

  assign w_xtime = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      round_q <= '0;
      rcon_q  <= 8'h00;
      ark_q   <= 1'b0;
      ren_q   <= 1'b0;
      mix_q   <= 1'b0;
      step_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      ark_q   <= ark_d;
      ren_q   <= ren_d;
      mix_q   <= mix_d;
      step_q  <= step_d;
      ov_q    <= ov_d;
    end
  end

  // w_adv marks entry into a new active round on the coming edge
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    w_adv   = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (in_valid) begin
          state_d = c_INIT;
          round_d = '0;
          rcon_d  = 8'h00;
        end
      end
      c_INIT: begin
        if (!w_stall) begin
          state_d = c_ROUND;
          round_d = RW'(1);
          w_adv   = 1'b1;
        end
      end
      c_ROUND: begin
        if (!w_stall) begin
          if (round_q == c_NR_LAST) begin
            state_d = c_DONE;
          end else begin
            round_d = round_q + 1'b1;
            w_adv   = 1'b1;
          end
        end
      end
      c_DONE: begin
        if (out_ready) begin
          state_d = c_IDLE;
          round_d = '0;
          rcon_d  = 8'h00;
        end
      end
      default: state_d = c_IDLE;
    endcase
    // AES-256 consumes a round constant only every second round
    if (w_adv && ((NR != 14) || !round_d[0])) begin
      rcon_d = (rcon_q == 8'h00) ? 8'h01 : w_xtime;
    end
  end

  always_comb begin
    ark_d  = (state_q == c_IDLE) && in_valid;
    ren_d  = w_adv;
    step_d = w_adv && ((NR != 14) || !round_d[0]);
    mix_d  = w_stall ? mix_q : (w_adv && (round_d != c_NR_LAST));
    ov_d   = (state_d == c_DONE);
  end

  assign in_ready  = (state_q == c_IDLE);
  assign ark_init  = ark_q;
  assign round_en  = ren_q;
  assign mix_en    = mix_q;
  assign round     = round_q;
  assign rcon_step = step_q;
  assign rcon      = rcon_q;
  assign out_valid = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_aes_round_ctrl                                              |
// | Brief   : Scoreboard bench for aes_round_ctrl (NR=10 and NR=14 builds).  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
`ifdef AES_CTRL_STALL_EN
  logic stall;
`endif
  logic       ir10, ark10, ren10, mix10, step10, ov10;
  logic [3:0] rnd10;
  logic [7:0] rc10;
  logic       ir14, ark14, ren14, mix14, step14, ov14;
  logic [3:0] rnd14;
  logic [7:0] rc14;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir10),
    .ark_init(ark10), .round_en(ren10), .mix_en(mix10), .round(rnd10),
    .rcon_step(step10), .rcon(rc10), .out_valid(ov10), .out_ready(out_ready)
`ifdef AES_CTRL_STALL_EN
    , .stall(stall)
`endif
  );

  aes_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir14),
    .ark_init(ark14), .round_en(ren14), .mix_en(mix14), .round(rnd14),
    .rcon_step(step14), .rcon(rc14), .out_valid(ov14), .out_ready(out_ready)
`ifdef AES_CTRL_STALL_EN
    , .stall(stall)
`endif
  );

  typedef struct packed {
    logic       ck_rnd, ck_rcon, ck_mix;
    logic       ir, ark, ren, mix;
    logic [3:0] rnd;
    logic       step;
    logic [7:0] rcon;
    logic       ov;
  } exp_t;

  typedef struct {
    int         nr;
    int         rnd;
    logic       step;
    logic [7:0] rcon;
    logic       mix;
  } vec_t;

  vec_t       tbl[24];
  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         sel14 = 1'b0;
  logic [7:0] r10[10];
  logic [7:0] r14[14];

  function automatic exp_t mk(logic cr, logic cc, logic cm, logic ir, logic ark, logic ren,
                              logic mix, logic [3:0] rnd, logic step, logic [7:0] rc, logic ov);
    exp_t e;
    e = '{ck_rnd:cr, ck_rcon:cc, ck_mix:cm, ir:ir, ark:ark, ren:ren, mix:mix,
          rnd:rnd, step:step, rcon:rc, ov:ov};
    return e;
  endfunction

  function automatic void push_init();
    q.push_back(mk(1, 1, 0, 0, 1, 0, 0, 4'd0, 0, 8'h00, 0));
  endfunction

  function automatic void push_round(int nr, int r);
    foreach (tbl[i])
      if (tbl[i].nr == nr && tbl[i].rnd == r)
        q.push_back(mk(1, 1, 1, 0, 0, 1, tbl[i].mix, 4'(r), tbl[i].step, tbl[i].rcon, 0));
  endfunction

  function automatic void push_done(int nr);
    q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'(nr), 0, 8'h00, 1));
  endfunction

  function automatic void push_idle(logic full);
    q.push_back(mk(full, full, full, 1, 0, 0, 0, 4'd0, 0, 8'h00, 0));
  endfunction

  function automatic void push_block(int nr, int ndone);
    push_init();
    for (int r = 1; r <= nr; r++) push_round(nr, r);
    for (int d = 0; d < ndone; d++) push_done(nr);
    push_idle(1'b0);
  endfunction

  function automatic exp_t sample();
    exp_t a;
    if (sel14) a = mk(1, 1, 1, ir14, ark14, ren14, mix14, rnd14, step14, rc14, ov14);
    else       a = mk(1, 1, 1, ir10, ark10, ren10, mix10, rnd10, step10, rc10, ov10);
    return a;
  endfunction

  task automatic cycle(string name);
    exp_t a, e;
    @(posedge clk);
    #1;
    cyc++;
    a = sample();
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s cyc%0d: scoreboard empty, got rnd=%0d ov=%b", name, cyc, a.rnd, a.ov);
    end else begin
      e = q.pop_front();
      a.ck_rnd = e.ck_rnd; a.ck_rcon = e.ck_rcon; a.ck_mix = e.ck_mix;
      if (!e.ck_rnd)  a.rnd  = e.rnd;
      if (!e.ck_rcon) a.rcon = e.rcon;
      if (!e.ck_mix)  a.mix  = e.mix;
      if (a !== e)
        $display("FAIL %s cyc%0d: got ir=%b ark=%b ren=%b mix=%b rnd=%0d step=%b rcon=%h ov=%b want ir=%b ark=%b ren=%b mix=%b rnd=%0d step=%b rcon=%h ov=%b",
                 name, cyc, a.ir, a.ark, a.ren, a.mix, a.rnd, a.step, a.rcon, a.ov,
                 e.ir, e.ark, e.ren, e.mix, e.rnd, e.step, e.rcon, e.ov);
      if (a !== e) errors++;
    end
  endtask

  task automatic do_reset(string name);
    rst = 1'b1;
    push_idle(1'b1);
    cycle(name);
    rst = 1'b0;
  endtask

  initial begin
    r10 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    r14 = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04,
            8'h08, 8'h08, 8'h10, 8'h10, 8'h20, 8'h20, 8'h40};
    for (int i = 0; i < 10; i++) tbl[i] = '{10, i + 1, 1'b1, r10[i], (i != 9)};
    for (int i = 0; i < 14; i++) tbl[10 + i] = '{14, i + 1, ((i + 1) % 2 == 0), r14[i], (i != 13)};

    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef AES_CTRL_STALL_EN
    stall = 1'b0;
`endif
    do_reset("reset");
    push_idle(1'b1);
    cycle("idle");

    // basic NR=10 block
    in_valid = 1'b1;
    push_block(10, 1);
    cycle("t1");
    in_valid = 1'b0;
    repeat (12) cycle("t1");

    // DONE backpressure with in_valid held high
    in_valid = 1'b1;
    out_ready = 1'b0;
    push_block(10, 6);
    repeat (17) cycle("t2_hold");
    out_ready = 1'b1;
    cycle("t2_idle");
    push_block(10, 1);
    cycle("t2_next");
    in_valid = 1'b0;
    repeat (12) cycle("t2_next");

    // reset in the middle of a block
    in_valid = 1'b1;
    push_init();
    for (int r = 1; r <= 5; r++) push_round(10, r);
    cycle("t3_pre");
    in_valid = 1'b0;
    repeat (5) cycle("t3_pre");
    do_reset("t3_rst");
    in_valid = 1'b1;
    push_block(10, 1);
    cycle("t3_post");
    in_valid = 1'b0;
    repeat (12) cycle("t3_post");

    // AES-256 schedule
    sel14 = 1'b1;
    do_reset("t4_rst");
    in_valid = 1'b1;
    push_block(14, 1);
    cycle("t4");
    in_valid = 1'b0;
    repeat (16) cycle("t4");
    sel14 = 1'b0;
    do_reset("t4_back");

`ifdef AES_CTRL_STALL_EN
    in_valid = 1'b1;
    push_init();
    for (int r = 1; r <= 3; r++) push_round(10, r);
    cycle("t5");
    in_valid = 1'b0;
    repeat (3) cycle("t5");
    stall = 1'b1;
    repeat (3) q.push_back(mk(1, 1, 1, 0, 0, 0, 1, 4'd3, 0, 8'h04, 0));
    repeat (3) cycle("t5_stall");
    stall = 1'b0;
    for (int r = 4; r <= 10; r++) push_round(10, r);
    push_done(10);
    push_idle(1'b0);
    repeat (9) cycle("t5_resume");
`endif

    // back-to-back blocks at the minimum period
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_block(10, 1);
      repeat (13) cycle("t6");
    end
    in_valid = 1'b0;

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d queued entries, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
